// File: rtl/pipelined_core_pkg.sv
// Shared opcodes and instruction field helpers for pipelined_core_p.
// Helpers take a zero-extended word and the register address width.
package pipelined_core_pkg;

  localparam int RA_MAX = 8;
  localparam int IW_MAX = 2 + 2*RA_MAX;

  typedef logic [IW_MAX-1:0] word_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_NOP = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  function automatic logic [1:0] f_op(
    input word_t w,
    input int ra
  );
    return 2'(w >> (2*ra));
  endfunction

  function automatic logic [RA_MAX-1:0] f_rd(
    input word_t w,
    input int ra
  );
    word_t m;
    m = (word_t'(1) << ra) - word_t'(1);
    return RA_MAX'((w >> ra) & m);
  endfunction

  function automatic logic [RA_MAX-1:0] f_rs(
    input word_t w,
    input int ra
  );
    word_t m;
    m = (word_t'(1) << ra) - word_t'(1);
    return RA_MAX'(w & m);
  endfunction

  // NOP word: op=10 with rd=rs=0
  function automatic word_t f_nop(input int ra);
    return word_t'(OP_NOP) << (2*ra);
  endfunction

endpackage

// File: rtl/core_regfile_p.sv
// 2R+1W register file, async reset to R[i]=i, write-through on A/B.
// Ports: we/waddr/wdata write; raddr_a/b bypassed reads; dbg_* raw read.
module core_regfile_p
  import pipelined_core_pkg::*;
#(
  parameter int DW = 8,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RA-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RA-1:0] raddr_a,
  input  logic [RA-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  input  logic [RA-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  logic [DW-1:0] regs [2**RA];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**RA; i++)
        regs[i] <= DW'(i);
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // a WB write in flight is visible to the ID read in the same cycle
  assign rdata_a = (we && waddr == raddr_a)
                 ? wdata : regs[raddr_a];
  assign rdata_b = (we && waddr == raddr_b)
                 ? wdata : regs[raddr_b];

  assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: rtl/pipelined_core_p.sv
// IF/ID/EX/WB core: ADD, SLL, NOP, JMP with loadable imem and run stall.
// Ports: run, imem_*, dbg_* in; pc, retire_*, halted out.
module pipelined_core_p
  import pipelined_core_pkg::*;
#(
  parameter  int DW     = 8,
  parameter  int RA     = 3,
  parameter  int IDEPTH = 64,
  localparam int PW     = $clog2(IDEPTH),
  localparam int IW     = 2 + 2*RA
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          imem_we,
  input  logic [PW-1:0] imem_addr,
  input  logic [IW-1:0] imem_wdata,
  input  logic [RA-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata,
  output logic [PW-1:0] pc,
  output logic          retire_valid,
  output logic [RA-1:0] retire_rd,
  output logic [DW-1:0] retire_data,
  output logic [15:0]   retire_count,
  output logic          halted
);

  localparam logic [IW-1:0] NOP_I = IW'(f_nop(RA));

  logic [IW-1:0] imem [IDEPTH];

  logic [IW-1:0] if_i;
  logic [1:0]    if_op;
  logic [RA-1:0] if_rd;
  logic [RA-1:0] if_rs;
  logic [PW-1:0] jmp_pc;
  logic [PW-1:0] next_pc;
  logic          is_jmp;
  logic          self_jmp;

  logic [IW-1:0] id_i;
  logic          id_v;
  logic [1:0]    id_op;
  logic [RA-1:0] id_rd;
  logic [RA-1:0] id_rs;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;

  logic [1:0]    ex_op;
  logic [RA-1:0] ex_rd;
  logic [RA-1:0] ex_rs;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic          ex_v;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] ex_res;
  logic          ex_we;

  logic          wb_we;
  logic [RA-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  // imem: no reset, loader writes only while stalled
  always_ff @(posedge clk) begin
    if (imem_we && !run)
      imem[imem_addr] <= imem_wdata;
  end

  assign if_i  = imem[pc];
  assign if_op = f_op(word_t'(if_i), RA);
  assign if_rd = RA'(f_rd(word_t'(if_i), RA));
  assign if_rs = RA'(f_rs(word_t'(if_i), RA));

  // jump target replaces the low 2*RA pc bits
  if (PW > 2*RA) begin : g_jhi
    assign jmp_pc = {pc[PW-1:2*RA], if_rd, if_rs};
  end else begin : g_jlo
    logic [2*RA-1:0] tgt;
    assign tgt    = {if_rd, if_rs};
    assign jmp_pc = tgt[PW-1:0];
  end

  assign is_jmp   = (if_op == OP_JMP);
  assign self_jmp = is_jmp && (jmp_pc == pc);
  assign next_pc  = is_jmp ? jmp_pc : pc + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      halted <= 1'b0;
      id_i   <= NOP_I;
      id_v   <= 1'b0;
    end else if (run) begin
      if (!halted) begin
        pc   <= next_pc;
        id_i <= if_i;
        id_v <= 1'b1;
        if (self_jmp)
          halted <= 1'b1;
      end else begin
        id_i <= NOP_I;
        id_v <= 1'b0;
      end
    end
  end

  assign id_op = f_op(word_t'(id_i), RA);
  assign id_rd = RA'(f_rd(word_t'(id_i), RA));
  assign id_rs = RA'(f_rs(word_t'(id_i), RA));

  core_regfile_p #(
    .DW(DW),
    .RA(RA)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (retire_valid),
    .waddr    (wb_rd),
    .wdata    (wb_data),
    .raddr_a  (id_rd),
    .raddr_b  (id_rs),
    .rdata_a  (rf_a),
    .rdata_b  (rf_b),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
  );

  // EX operands take the WB result on an address match;
  // SLL uses rs as a shift amount, so only rd forwards.
  always_comb begin
    op_a = ex_a;
    if (wb_we && wb_rd == ex_rd)
      op_a = wb_data;
    op_b = ex_b;
    if (wb_we && ex_op == OP_ADD && wb_rd == ex_rs)
      op_b = wb_data;
    ex_res = '0;
    ex_we  = 1'b0;
    unique case (1'b1)
      (ex_op == OP_ADD): begin
        ex_res = op_a + op_b;
        ex_we  = ex_v;
      end
      (ex_op == OP_SLL): begin
        if (32'(ex_rs) >= DW)
          ex_res = '0;
        else
          ex_res = op_a << ex_rs;
        ex_we = ex_v;
      end
      default: begin
        ex_res = '0;
        ex_we  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_op   <= OP_NOP;
      ex_rd   <= '0;
      ex_rs   <= '0;
      ex_a    <= '0;
      ex_b    <= '0;
      ex_v    <= 1'b0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (run) begin
      ex_op   <= id_op;
      ex_rd   <= id_rd;
      ex_rs   <= id_rs;
      ex_a    <= rf_a;
      ex_b    <= rf_b;
      ex_v    <= id_v;
      wb_we   <= ex_we;
      wb_rd   <= ex_we ? ex_rd : '0;
      wb_data <= ex_we ? ex_res : '0;
    end
  end

  assign retire_valid = run && wb_we;
  assign retire_rd    = wb_rd;
  assign retire_data  = wb_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retire_count <= '0;
    else if (retire_valid && retire_count != 16'hFFFF)
      retire_count <= retire_count + 16'd1;
  end

endmodule

// File: tb/tb_pipelined_core_p.sv
// Bench for pipelined_core_p: directed programs plus random programs,
// checked cycle by cycle against an ISA-level model with 3-cycle retire.
module tb_pipelined_core_p;

  localparam int DW     = 8;
  localparam int RA     = 3;
  localparam int IDEPTH = 64;
  localparam int PW     = 6;
  localparam int IW     = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          imem_we;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic [RA-1:0] dbg_raddr;
  logic [DW-1:0] dbg_rdata;
  logic [PW-1:0] pc;
  logic          retire_valid;
  logic [RA-1:0] retire_rd;
  logic [DW-1:0] retire_data;
  logic [15:0]   retire_count;
  logic          halted;

  always #5 clk = ~clk;

  pipelined_core_p #(
    .DW(DW),
    .RA(RA),
    .IDEPTH(IDEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata),
    .pc          (pc),
    .retire_valid(retire_valid),
    .retire_rd   (retire_rd),
    .retire_data (retire_data),
    .retire_count(retire_count),
    .halted      (halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // architectural model: arch is updated at fetch, com at retire
  int m_imem [IDEPTH];
  int m_arch [8];
  int m_com  [8];
  int m_pc;
  bit m_halt;
  int m_cnt;
  bit p_wr  [3];
  int p_rd  [3];
  int p_dat [3];

  function automatic void m_reset();
    m_pc   = 0;
    m_halt = 0;
    m_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      m_arch[i] = i;
      m_com[i]  = i;
    end
    for (int i = 0; i < 3; i++) begin
      p_wr[i]  = 0;
      p_rd[i]  = 0;
      p_dat[i] = 0;
    end
  endfunction

  function automatic void m_edge(
    input bit r,
    input bit we,
    input int addr,
    input int wd
  );
    int w, op, rd, rs, v, tgt;
    if (!r) begin
      if (we)
        m_imem[addr] = wd;
      return;
    end
    if (p_wr[2]) begin
      m_com[p_rd[2]] = p_dat[2];
      if (m_cnt < 65535)
        m_cnt++;
    end
    for (int i = 2; i > 0; i--) begin
      p_wr[i]  = p_wr[i-1];
      p_rd[i]  = p_rd[i-1];
      p_dat[i] = p_dat[i-1];
    end
    p_wr[0]  = 0;
    p_rd[0]  = 0;
    p_dat[0] = 0;
    if (m_halt)
      return;
    w  = m_imem[m_pc];
    op = (w >> 6) & 3;
    rd = (w >> 3) & 7;
    rs = w & 7;
    case (op)
      0: begin
        v = (m_arch[rd] + m_arch[rs]) % 256;
        m_arch[rd] = v;
        p_wr[0] = 1; p_rd[0] = rd; p_dat[0] = v;
        m_pc = (m_pc + 1) % IDEPTH;
      end
      1: begin
        v = (rs >= DW) ? 0 : (m_arch[rd] << rs) % 256;
        m_arch[rd] = v;
        p_wr[0] = 1; p_rd[0] = rd; p_dat[0] = v;
        m_pc = (m_pc + 1) % IDEPTH;
      end
      2: m_pc = (m_pc + 1) % IDEPTH;
      default: begin
        tgt = w & 63;
        if (tgt == m_pc)
          m_halt = 1;
        m_pc = tgt;
      end
    endcase
  endfunction

  // one clock: called at negedge, returns at next negedge
  task automatic cyc(input bit r);
    run = r;
    dbg_raddr = RA'($urandom);
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("rvalid", 32'(retire_valid), 32'(r && p_wr[2]));
    if (r && p_wr[2]) begin
      chk("rrd", 32'(retire_rd), 32'(p_rd[2]));
      chk("rdata", 32'(retire_data), 32'(p_dat[2]));
    end
    chk("rcount", 32'(retire_count), 32'(m_cnt));
    chk("dbg", 32'(dbg_rdata), 32'(m_com[dbg_raddr]));
    @(posedge clk);
    m_edge(r, imem_we, 32'(imem_addr), 32'(imem_wdata));
    @(negedge clk);
  endtask

  task automatic do_reset();
    run = 1'b0;
    imem_we = 1'b0;
    reset = 1'b0;
    #1;
    m_reset();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halt", 32'(halted), 0);
    chk("rst_rv", 32'(retire_valid), 0);
    chk("rst_rrd", 32'(retire_rd), 0);
    chk("rst_rdata", 32'(retire_data), 0);
    chk("rst_cnt", 32'(retire_count), 0);
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = RA'(i);
      #1;
      chk("rst_reg", 32'(dbg_rdata), 32'(i));
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load(input int prog[$]);
    for (int a = 0; a < IDEPTH; a++) begin
      imem_we    = 1'b1;
      imem_addr  = PW'(a);
      imem_wdata = (a < prog.size()) ? IW'(prog[a]) : 8'h80;
      cyc(1'b0);
    end
    imem_we = 1'b0;
  endtask

  task automatic runn(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1);
  endtask

  task automatic dchk(input string tag, input int idx, input int exp);
    dbg_raddr = RA'(idx);
    #1;
    chk(tag, 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic final1(input string tag);
    #1;
    chk({tag, "_halt"}, 32'(halted), 1);
    chk({tag, "_pc"}, 32'(pc), 5);
    chk({tag, "_cnt"}, 32'(retire_count), 2);
    dchk({tag, "_r3"}, 3, 4);
    dchk({tag, "_r1"}, 1, 2);
  endtask

  int prog1[$] = '{8'h19, 8'h49, 8'h80, 8'h80, 8'h80, 8'hC5};

  initial begin
    reset      = 1'b0;
    run        = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    dbg_raddr  = '0;
    for (int i = 0; i < IDEPTH; i++)
      m_imem[i] = 0;
    m_reset();
    @(negedge clk);

    do_reset();
    load(prog1);
    runn(12);
    final1("basic");

    do_reset();
    load('{8'h19, 8'h1B, 8'hC2});
    runn(10);
    dchk("b2b_r3", 3, 8);
    chk("b2b_cnt", 32'(retire_count), 2);

    do_reset();
    load('{8'h19, 8'h80, 8'h1B, 8'hC3});
    runn(10);
    dchk("d2_r3", 3, 8);

    do_reset();
    load('{8'h80, 8'h80, 8'h80, 8'hC5, 8'h09, 8'hC5});
    runn(10);
    dchk("jmp_r1", 1, 1);
    chk("jmp_pc", 32'(pc), 5);
    chk("jmp_cnt", 32'(retire_count), 0);

    do_reset();
    load(prog1);
    runn(3);
    for (int i = 0; i < 3; i++)
      cyc(1'b0);
    runn(10);
    final1("stall");

    runn(0);
    do_reset();
    runn(3);
    do_reset();
    runn(12);
    final1("rerun");

    for (int it = 0; it < 6; it++) begin
      int q[$];
      bit r;
      q = {};
      for (int a = 0; a < IDEPTH; a++)
        q.push_back(int'($urandom_range(0, 255)));
      do_reset();
      load(q);
      for (int c = 0; c < 150; c++) begin
        r = ($urandom_range(0, 9) != 0);
        imem_we    = 1'($urandom_range(0, 1));
        imem_addr  = PW'($urandom);
        imem_wdata = IW'($urandom);
        if ($urandom_range(0, 3) == 0)
          imem_addr = pc;
        cyc(r);
      end
      imem_we = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
